// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared state encoding and tile timing for the systolic array and its sequencer
package systolic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREFETCH,
    ST_COMPUTE,
    ST_READOUT,
    ST_DONE
  } state_t;

  localparam int ARRAY_SIZE_DEF    = 8;
  localparam int K_ACCUM_DEPTH_DEF = 8;

  // Compute window: fill the array diagonal, one skew cycle, then K accumulations.
  function automatic int compute_len(input int array_size, input int k_depth);
    return array_size + 1 + k_depth;
  endfunction

  function automatic int first_out_offset(input int array_size);
    return array_size + 1;
  endfunction

  localparam int COMPUTE_LEN      = compute_len(ARRAY_SIZE_DEF, K_ACCUM_DEPTH_DEF);
  localparam int FIRST_OUT_OFFSET = first_out_offset(ARRAY_SIZE_DEF);

endpackage

// File: rtl/systolic_ctrl_if.sv
// rtl/systolic_ctrl_if.sv - command, SRAM read, array control and readout handshake bundle
interface systolic_ctrl_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  start;
  logic [7:0]            num_tiles;
  logic [ADDR_WIDTH-1:0] w_base;
  logic [ADDR_WIDTH-1:0] d_base;
  logic                  sram_ren;
  logic [ADDR_WIDTH-1:0] sram_raddr_w;
  logic [ADDR_WIDTH-1:0] sram_raddr_d;
  logic                  alu_start;
  logic [8:0]            cycle_num;
  logic [5:0]            matrix_index;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, num_tiles, w_base, d_base, out_ready,
    output sram_ren, sram_raddr_w, sram_raddr_d, alu_start, cycle_num,
           matrix_index, out_valid, busy, done
  );

  modport slave (
    output start, num_tiles, w_base, d_base, out_ready,
    input  sram_ren, sram_raddr_w, sram_raddr_d, alu_start, cycle_num,
           matrix_index, out_valid, busy, done
  );

endinterface

// File: rtl/systolic_ctrl_sram_addr_gen.sv
// rtl/systolic_ctrl_sram_addr_gen.sv - latched bases plus per-tile offset plus step, wrapping in ADDR_WIDTH
module sram_addr_gen #(
  parameter int ADDR_WIDTH  = 10,
  parameter int COMPUTE_LEN = 17
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  i_latch,
  input  logic [ADDR_WIDTH-1:0] i_w_base,
  input  logic [ADDR_WIDTH-1:0] i_d_base,
  input  logic                  i_tile_adv,
  input  logic                  i_ren,
  input  logic [8:0]            i_step,
  output logic                  o_ren,
  output logic [ADDR_WIDTH-1:0] o_raddr_w,
  output logic [ADDR_WIDTH-1:0] o_raddr_d
);

  logic [ADDR_WIDTH-1:0] r_w_base;
  logic [ADDR_WIDTH-1:0] r_d_base;
  logic [ADDR_WIDTH-1:0] r_tile_off;
  logic [ADDR_WIDTH-1:0] w_off;

  always_ff @(posedge clk) begin
    if (!srstn) begin
      r_w_base   <= '0;
      r_d_base   <= '0;
      r_tile_off <= '0;
    end else if (i_latch) begin
      r_w_base   <= i_w_base;
      r_d_base   <= i_d_base;
      r_tile_off <= '0;
    end else if (i_tile_adv) begin
      r_tile_off <= r_tile_off + ADDR_WIDTH'(COMPUTE_LEN);
    end
  end

  // Addresses read as zero whenever the SRAMs are not being read.
  assign w_off     = r_tile_off + ADDR_WIDTH'(i_step);
  assign o_ren     = i_ren;
  assign o_raddr_w = i_ren ? (r_w_base + w_off) : '0;
  assign o_raddr_d = i_ren ? (r_d_base + w_off) : '0;

endmodule

// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - per-tile sequencer: SRAM prefetch, array compute window, handshaked row readout
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE    = 8,
  parameter int K_ACCUM_DEPTH = 8,
  parameter int ADDR_WIDTH    = 10
) (
  input  logic            clk,
  input  logic            srstn,
  systolic_ctrl_if.master bus
);

  localparam int         COMPUTE_LEN = compute_len(ARRAY_SIZE, K_ACCUM_DEPTH);
  localparam logic [8:0] LAST_CYCLE  = 9'(COMPUTE_LEN - 1);
  localparam logic [5:0] LAST_INDEX  = 6'(ARRAY_SIZE - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [8:0] r_cycle_num;
  logic [8:0] w_next_cycle;
  logic [5:0] r_matrix_index;
  logic [5:0] w_next_index;
  logic [7:0] r_tile_cnt;
  logic [7:0] w_next_tile;
  logic [7:0] r_num_tiles;
  logic       w_latch;
  logic       w_tile_adv;
  logic       w_ren;
  logic [8:0] w_step;

  always_ff @(posedge clk) begin
    if (!srstn) begin
      r_state        <= ST_IDLE;
      r_cycle_num    <= '0;
      r_matrix_index <= '0;
      r_tile_cnt     <= '0;
      r_num_tiles    <= '0;
    end else begin
      r_state        <= w_next_state;
      r_cycle_num    <= w_next_cycle;
      r_matrix_index <= w_next_index;
      r_tile_cnt     <= w_next_tile;
      if (w_latch) begin
        r_num_tiles <= bus.num_tiles;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cycle = r_cycle_num;
    w_next_index = r_matrix_index;
    w_next_tile  = r_tile_cnt;
    w_latch      = 1'b0;
    w_tile_adv   = 1'b0;
    w_ren        = 1'b0;
    w_step       = '0;

    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_latch      = 1'b1;
          w_next_tile  = '0;
          w_next_cycle = '0;
          w_next_index = '0;
          w_next_state = (bus.num_tiles == 8'd0) ? ST_DONE : ST_PREFETCH;
        end
      end
      ST_PREFETCH: begin
        w_ren        = 1'b1;
        w_next_cycle = '0;
        w_next_state = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        // Reads run one step ahead so SRAM data lands on the matching compute step.
        w_ren  = (r_cycle_num < LAST_CYCLE);
        w_step = r_cycle_num + 9'd1;
        if (r_cycle_num == LAST_CYCLE) begin
          w_next_cycle = '0;
          w_next_index = '0;
          w_next_state = ST_READOUT;
        end else begin
          w_next_cycle = r_cycle_num + 9'd1;
        end
      end
      ST_READOUT: begin
        if (bus.out_ready) begin
          if (r_matrix_index == LAST_INDEX) begin
            w_next_index = '0;
            if (({1'b0, r_tile_cnt} + 9'd1) < {1'b0, r_num_tiles}) begin
              w_next_tile  = r_tile_cnt + 8'd1;
              w_tile_adv   = 1'b1;
              w_next_state = ST_PREFETCH;
            end else begin
              w_next_state = ST_DONE;
            end
          end else begin
            w_next_index = r_matrix_index + 6'd1;
          end
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase

    bus.busy         = (r_state != ST_IDLE);
    bus.done         = (r_state == ST_DONE);
    bus.alu_start    = (r_state == ST_COMPUTE);
    bus.out_valid    = (r_state == ST_READOUT);
    bus.cycle_num    = r_cycle_num;
    bus.matrix_index = r_matrix_index;
  end

  sram_addr_gen #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .COMPUTE_LEN (COMPUTE_LEN)
  ) u_addr_gen (
    .clk        (clk),
    .srstn      (srstn),
    .i_latch    (w_latch),
    .i_w_base   (bus.w_base),
    .i_d_base   (bus.d_base),
    .i_tile_adv (w_tile_adv),
    .i_ren      (w_ren),
    .i_step     (w_step),
    .o_ren      (bus.sram_ren),
    .o_raddr_w  (bus.sram_raddr_w),
    .o_raddr_d  (bus.sram_raddr_d)
  );

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb/tb_systolic_ctrl.sv - scoreboard bench for systolic_ctrl: directed jobs, monitor pops expected reads, beats, done
module tb_systolic_ctrl;
  import systolic_pkg::*;

  localparam int AW = 10;
  localparam int AS = 8;
  localparam int CL = 17;
  localparam int TILE_CYCLES = 1 + CL + AS;

  typedef struct {
    logic [AW-1:0] w;
    logic [AW-1:0] d;
    logic          alu;
    logic [8:0]    cyc;
  } rd_exp_t;

  logic clk = 1'b0;
  logic srstn = 1'b0;
  always #5 clk = ~clk;

  systolic_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  systolic_ctrl #(
    .ARRAY_SIZE    (AS),
    .K_ACCUM_DEPTH (8),
    .ADDR_WIDTH    (AW)
  ) dut (
    .clk   (clk),
    .srstn (srstn),
    .bus   (bus)
  );

  int      n_tests = 0;
  int      n_fail = 0;
  int      cyc = 0;
  int      alu_cnt = 0;
  int      ren_cnt = 0;
  int      beat_cnt = 0;
  bit      done_seen = 1'b0;
  rd_exp_t rd_q[$];
  int      beat_q[$];
  int      done_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Monitor: samples 1ns after the falling edge, when the drivers have settled this cycle's inputs.
  initial begin
    rd_exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (srstn) begin
        if (bus.sram_ren) begin
          ren_cnt++;
          if (rd_q.size() == 0) fail_now("sram_ren_unexpected");
          else begin
            e = rd_q.pop_front();
            chk("raddr_w", 32'(bus.sram_raddr_w), 32'(e.w));
            chk("raddr_d", 32'(bus.sram_raddr_d), 32'(e.d));
            chk("alu_start_with_read", 32'(bus.alu_start), 32'(e.alu));
            chk("cycle_num_with_read", 32'(bus.cycle_num), 32'(e.cyc));
          end
        end
        if (bus.alu_start) begin
          alu_cnt++;
          if (!bus.sram_ren) chk("cycle_num_last", 32'(bus.cycle_num), 32'(CL - 1));
        end
        if (bus.out_valid) begin
          chk("alu_start_in_readout", 32'(bus.alu_start), 32'd0);
          if (bus.out_ready) begin
            beat_cnt++;
            if (beat_q.size() == 0) fail_now("beat_unexpected");
            else chk("matrix_index", 32'(bus.matrix_index), 32'(beat_q.pop_front()));
          end
        end
        if (bus.done) begin
          chk("busy_in_done", 32'(bus.busy), 32'd1);
          if (done_q.size() == 0) fail_now("done_unexpected");
          else chk("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
          done_seen = 1'b1;
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_sram_ren"}, 32'(bus.sram_ren), 32'd0);
    chk({tag, "_alu_start"}, 32'(bus.alu_start), 32'd0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_cycle_num"}, 32'(bus.cycle_num), 32'd0);
    chk({tag, "_matrix_index"}, 32'(bus.matrix_index), 32'd0);
    chk({tag, "_raddr_w"}, 32'(bus.sram_raddr_w), 32'd0);
    chk({tag, "_raddr_d"}, 32'(bus.sram_raddr_d), 32'd0);
  endtask

  task automatic wait_idle();
    int budget;
    budget = 200;
    @(negedge clk);
    while (bus.busy && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (bus.busy) fail_now("idle_timeout");
  endtask

  task automatic push_job(input int nt, input logic [AW-1:0] wb, input logic [AW-1:0] db);
    logic [AW-1:0] off;
    for (int t = 0; t < nt; t++) begin
      for (int s = 0; s < CL; s++) begin
        off = AW'(t * CL + s);
        rd_q.push_back('{w: wb + off, d: db + off, alu: (s != 0), cyc: 9'((s == 0) ? 0 : s - 1)});
      end
      for (int b = 0; b < AS; b++) beat_q.push_back(b);
    end
  endtask

  task automatic run_job(input int nt, input logic [AW-1:0] wb, input logic [AW-1:0] db,
                         input int stall_idx, input int stall_len, input bit glitch);
    int c0;
    int budget;
    bit stalled;
    wait_idle();
    alu_cnt   = 0;
    ren_cnt   = 0;
    beat_cnt  = 0;
    done_seen = 1'b0;
    push_job(nt, wb, db);
    bus.start     = 1'b1;
    bus.num_tiles = 8'(nt);
    bus.w_base    = wb;
    bus.d_base    = db;
    c0 = cyc;
    done_q.push_back(c0 + nt * TILE_CYCLES + 1 + stall_len);
    @(negedge clk);
    bus.start     = 1'b0;
    bus.num_tiles = 8'(nt + 3);
    bus.w_base    = ~wb;
    bus.d_base    = ~db;
    stalled = 1'b0;
    budget  = nt * TILE_CYCLES + 20;
    while (!done_seen && budget > 0) begin
      bus.start = 1'b0;
      if (glitch && ((bus.alu_start && bus.cycle_num == 9'd5) ||
                     (bus.out_valid && bus.matrix_index == 6'd1))) begin
        bus.start     = 1'b1;
        bus.num_tiles = 8'd5;
        bus.w_base    = 10'h155;
        bus.d_base    = 10'h2AA;
      end
      if (stall_idx >= 0 && !stalled && bus.out_valid && bus.matrix_index == 6'(stall_idx)) begin
        stalled = 1'b1;
        bus.out_ready = 1'b0;
        repeat (stall_len) begin
          @(negedge clk);
          chk("stall_index_held", 32'(bus.matrix_index), 32'(stall_idx));
          chk("stall_valid_held", 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
      end
      @(negedge clk);
      budget--;
    end
    bus.start = 1'b0;
    if (!done_seen) fail_now("done_timeout");
    chk("busy_after_done", 32'(bus.busy), 32'd0);
    #2;
    chk("alu_cycles", 32'(alu_cnt), 32'(nt * CL));
    chk("read_cycles", 32'(ren_cnt), 32'(nt * CL));
    chk("beats", 32'(beat_cnt), 32'(nt * AS));
    chk("reads_left", 32'(rd_q.size()), 32'd0);
    chk("beats_left", 32'(beat_q.size()), 32'd0);
    chk("done_left", 32'(done_q.size()), 32'd0);
  endtask

  task automatic reset_mid_compute();
    int budget;
    wait_idle();
    done_seen = 1'b0;
    push_job(1, 10'h080, 10'h300);
    bus.start     = 1'b1;
    bus.num_tiles = 8'd1;
    bus.w_base    = 10'h080;
    bus.d_base    = 10'h300;
    @(negedge clk);
    bus.start = 1'b0;
    budget = 40;
    while (!(bus.alu_start && bus.cycle_num == 9'd9) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) fail_now("reach_cycle9_timeout");
    srstn = 1'b0;
    @(negedge clk);
    check_reset_vals("mid_reset");
    rd_q.delete();
    beat_q.delete();
    done_q.delete();
    srstn = 1'b1;
    repeat (30) @(negedge clk);
    chk("no_done_after_reset", 32'(done_seen), 32'd0);
    chk("idle_after_reset", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.num_tiles = '0;
    bus.w_base    = '0;
    bus.d_base    = '0;
    bus.out_ready = 1'b1;
    srstn         = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    srstn = 1'b1;

    run_job(1, 10'h010, 10'h200, -1, 0, 1'b0);
    run_job(1, 10'h010, 10'h200, 3, 5, 1'b0);
    run_job(3, 10'h040, 10'h100, -1, 0, 1'b0);
    run_job(0, 10'h123, 10'h321, -1, 0, 1'b0);
    run_job(1, 10'h3F8, 10'h3FC, -1, 0, 1'b0);
    run_job(2, 10'h0A0, 10'h1B0, 6, 2, 1'b1);
    reset_mid_compute();
    run_job(1, 10'h080, 10'h300, -1, 0, 1'b0);
    run_job(255, 10'h3E0, 10'h000, -1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencer for the 8×8 `systolic` MAC array. It accepts a job of one or more tiles and, for each tile:
- drives the weight/data SRAM read addresses and enables;
- generates `alu_start` and `cycle_num` for the array;
- steps `matrix_index` through the array rows under a valid/ready handshake to the downstream result writer.

It sits between the top-level command interface, the SRAMs and the array.

## Interface
Parameters:
- ARRAY_SIZE, 8, array rows/columns; readout beats per tile
- K_ACCUM_DEPTH, 8, accumulation depth programmed into the array
- ADDR_WIDTH, 10, SRAM read address width
- COMPUTE_LEN (localparam), ARRAY_SIZE+1+K_ACCUM_DEPTH, compute cycles per tile (17 at defaults); must be ≤ 511

Ports:
- clk  in  1  clock
- srstn  in  1  reset, synchronous, active-low
- start  in  1  job request, sampled in IDLE only
- num_tiles  in  8  tiles in job, latched on accepted start
- w_base  in  ADDR_WIDTH  weight SRAM base address, latched on start
- d_base  in  ADDR_WIDTH  data SRAM base address, latched on start
- sram_ren  out  1  read enable, shared by weight and data SRAMs
- sram_raddr_w  out  ADDR_WIDTH  weight read address
- sram_raddr_d  out  ADDR_WIDTH  data read address
- alu_start  out  1  array compute enable
- cycle_num  out  9  array cycle counter
- matrix_index  out  6  array row selected for readout
- out_valid  out  1  mul_outcome row is valid
- out_ready  in  1  downstream accepts the row
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end

## Operation
FSM states: IDLE, PREFETCH, COMPUTE, READOUT, DONE.
- **IDLE**
  - busy=0.
  - start=1 latches num_tiles/w_base/d_base and clears tile_cnt.
  - Goes to PREFETCH, or to DONE if num_tiles==0.
  - start in any other state is ignored.
- **PREFETCH** (1 cycle)
  - sram_ren=1.
  - Addresses = base + tile_cnt·COMPUTE_LEN, covering SRAM read latency of 1.
  - Goes to COMPUTE.
- **COMPUTE** (COMPUTE_LEN cycles)
  - alu_start=1; cycle_num counts 0..COMPUTE_LEN-1.
  - sram_ren=1 while cycle_num < COMPUTE_LEN-1, with address offset cycle_num+1, so data for step c arrives at step c.
  - Last cycle goes to READOUT; cycle_num returns to 0.
- **READOUT**
  - alu_start=0, so the array holds its accumulators.
  - out_valid=1; matrix_index starts at 0.
  - On out_valid&&out_ready, index increments.
  - Accepted beat at index ARRAY_SIZE-1: tile_cnt+1 < num_tiles → PREFETCH (tile_cnt++, index 0); otherwise → DONE.
  - out_ready=0 holds index and out_valid, with no limit on stall length.
- **DONE** (1 cycle): done=1, busy=1, then → IDLE.
- busy=1 in every state except IDLE.

Arithmetic:
- Address offset = tile_cnt·COMPUTE_LEN + step, computed in ADDR_WIDTH bits; it wraps modulo 2^ADDR_WIDTH with no error.
- tile_cnt is 8 bits; num_tiles=255 is legal.

## Timing
Reset values:
- state=IDLE
- sram_ren=0, alu_start=0, out_valid=0, busy=0, done=0
- cycle_num=0, matrix_index=0, addresses=0

Latency and behaviour:
- All outputs are registered or decoded from registered state; no combinational path from out_ready to any output except through the state update.
- Accepted start at edge t: PREFETCH during cycle t+1, COMPUTE cycles t+2..t+1+COMPUTE_LEN, first out_valid at t+2+COMPUTE_LEN.
- Back-to-back tiles: after the final readout beat, the next cycle is PREFETCH (one bubble); alu_start is never asserted during READOUT.
- Reset low in any state returns to reset values on the next edge; the latched job is discarded and done is not pulsed.
- start held high through DONE is not accepted until IDLE, so a new job begins no earlier than one cycle after done.

## Structure
- Shared package `systolic_pkg`:
  - state enum
  - COMPUTE_LEN and the first-output offset ARRAY_SIZE+1, shared with `systolic` so both agree on K_ACCUM_DEPTH timing
- One natural sub-module: `sram_addr_gen` (base latch, tile-offset accumulator, step adder, ren).
- FSM, cycle counter and readout counter live in the top.

## Test plan
- **Single tile, defaults:** start at cycle 0 with w_base=0x010, d_base=0x200, num_tiles=1, out_ready=1.
  - PREFETCH at 1 with raddr_w=0x010.
  - alu_start cycles 2–18, cycle_num 0→16.
  - sram_ren is low from cycle 18; last addresses 0x020/0x210 at cycle 17.
  - out_valid cycles 19–26 with index 0–7; done at 27; busy low at 28.
- **Readout backpressure:** out_ready low for 5 cycles at index 3 → index held at 3 with out_valid=1; done delayed by exactly 5 cycles.
- **Three tiles:** tile 2 PREFETCH raddr_w = w_base+34.
  - One PREFETCH bubble between each tile's last beat and the next COMPUTE.
  - Exactly 24 accepted beats in total; exactly one done pulse.
- **Edge jobs:**
  - num_tiles=0 → busy for one cycle, done pulse; no sram_ren or alu_start.
  - w_base=0x3F8 → address wraps to 0x000 at offset 8.
- **Reset mid-COMPUTE:** srstn low at cycle_num=9 → all outputs at reset values on the next edge; no done. A new start after release runs a full job from cycle_num 0.
- **start ignored while busy:** start pulses during COMPUTE and READOUT do not re-latch bases or num_tiles, and the job completes unchanged.
